traffic_light_ctrl: RTL and testbench

- Lab 4 sequential stage directly downstream of the 100 MHz clock divider.
- Consumes the divider's slow square wave (~1.5 Hz) as a tick source, but stays in the clk100MHz domain. Edge-detects the slow wave to produce one-cycle tick enables.
- Runs a two-road traffic-light state machine with a latched pedestrian-walk request.
- Drives board LEDs directly.

---
 rtl/traffic_light_ctrl.sv | 88 ++++++++
 tb/tb_traffic_light_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road traffic light FSM with latched pedestrian walk request,
// ticked by edge-detected divider output sampled in the clk100MHz domain.
module traffic_light_ctrl #(
   parameter int T_GREEN  = 5,
   parameter int T_YELLOW = 2,
   parameter int T_ALLRED = 1,
   parameter int T_WALK   = 4,
   parameter int CNT_W    = 4
) (
   input  logic       clk100MHz,
   input  logic       rst,
   input  logic       slow_clk,
   input  logic       enable,
   input  logic       ped_req,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk,
   output logic [2:0] state,
   output logic       ped_pending
);
   typedef enum logic [2:0] {
      NS_GREEN, NS_YELLOW, ALL_RED_1, EW_GREEN, EW_YELLOW, ALL_RED_2, PED_WALK
   } state_t;
   state_t cur, nxt;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   logic [2:0] sl_sync, pr_sync;
   logic dir_ew, nxt_dir, tick, ped_edge, last, adv;
   int dur;
   assign tick     = sl_sync[1] & ~sl_sync[2];
   assign ped_edge = pr_sync[1] & ~pr_sync[2];
   assign state    = cur;
   assign dur  = (cur == NS_GREEN || cur == EW_GREEN) ? T_GREEN :
                 (cur == NS_YELLOW || cur == EW_YELLOW) ? T_YELLOW :
                 (cur == PED_WALK) ? T_WALK : T_ALLRED;
   assign last = cnt == CNT_W'(dur - 1);
   assign adv  = tick & enable;
   always_comb begin
      nxt     = cur;
      nxt_dir = dir_ew;
      nxt_cnt = adv ? (last ? '0 : cnt + 1'b1) : cnt;
      if (adv && last)
         case (cur)
            NS_GREEN:  nxt = NS_YELLOW;
            NS_YELLOW: nxt = ALL_RED_1;
            ALL_RED_1: begin
               nxt     = ped_pending ? PED_WALK : EW_GREEN;
               nxt_dir = ped_pending ? 1'b1 : dir_ew;
            end
            EW_GREEN:  nxt = EW_YELLOW;
            EW_YELLOW: nxt = ALL_RED_2;
            ALL_RED_2: begin
               nxt     = ped_pending ? PED_WALK : NS_GREEN;
               nxt_dir = ped_pending ? 1'b0 : dir_ew;
            end
            PED_WALK:  nxt = dir_ew ? EW_GREEN : NS_GREEN;
            default:   nxt = ALL_RED_2;
         endcase
      // Unused code 7 recovers to a safe all-red state regardless of ticks
      if (cur > PED_WALK) begin
         nxt     = ALL_RED_2;
         nxt_cnt = '0;
      end
   end
   always_ff @(posedge clk100MHz or negedge rst) begin
      if (!rst) begin
         sl_sync     <= '0;
         pr_sync     <= '0;
         cur         <= ALL_RED_2;
         cnt         <= '0;
         dir_ew      <= 1'b0;
         ped_pending <= 1'b0;
         ns_light    <= 3'b100;
         ew_light    <= 3'b100;
         walk        <= 1'b0;
      end else begin
         sl_sync     <= {sl_sync[1:0], slow_clk};
         pr_sync     <= {pr_sync[1:0], ped_req};
         cur         <= nxt;
         cnt         <= nxt_cnt;
         dir_ew      <= nxt_dir;
         ped_pending <= (nxt == PED_WALK && cur != PED_WALK) ? 1'b0 :
                        (ped_edge && cur != PED_WALK) ? 1'b1 : ped_pending;
         ns_light    <= nxt == NS_GREEN ? 3'b001 : nxt == NS_YELLOW ? 3'b010 : 3'b100;
         ew_light    <= nxt == EW_GREEN ? 3'b001 : nxt == EW_YELLOW ? 3'b010 : 3'b100;
         walk        <= nxt == PED_WALK;
      end
   end
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed scenario tasks for traffic_light_ctrl with
// hand-computed state/lamp expectations after each slow tick.
module tb_traffic_light_ctrl;
   logic clk100MHz = 1'b0;
   logic rst = 1'b0, slow_clk = 1'b0, enable = 1'b1, ped_req = 1'b0;
   logic [2:0] ns_light, ew_light, state;
   logic walk, ped_pending;
   int pass_cnt = 0, total_cnt = 0;

   traffic_light_ctrl dut (
      .clk100MHz(clk100MHz), .rst(rst), .slow_clk(slow_clk), .enable(enable),
      .ped_req(ped_req), .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
      .state(state), .ped_pending(ped_pending)
   );

   always #5 clk100MHz = ~clk100MHz;

   function automatic logic [9:0] expect_vec(input int s);
      logic [2:0] ns, ew;
      ns = s == 0 ? 3'b001 : s == 1 ? 3'b010 : 3'b100;
      ew = s == 3 ? 3'b001 : s == 4 ? 3'b010 : 3'b100;
      return {3'(s), ns, ew, 1'(s == 6)};
   endfunction

   // One slow-clock period: high 10 cycles, low 10 cycles; optional button press alongside
   task automatic do_tick(input bit press);
      @(negedge clk100MHz);
      slow_clk = 1'b1;
      if (press) ped_req = 1'b1;
      repeat (10) @(negedge clk100MHz);
      slow_clk = 1'b0;
      if (press) ped_req = 1'b0;
      repeat (10) @(negedge clk100MHz);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) do_tick(1'b0);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk100MHz);
      total_cnt++;
      if ({state, ns_light, ew_light, walk, ped_pending} !== {3'd5, 3'b100, 3'b100, 1'b0, 1'b0})
         $display("FAIL reset_vals: got st=%0d ns=%b ew=%b walk=%b pend=%b want st=5 ns=100 ew=100 walk=0 pend=0",
                  state, ns_light, ew_light, walk, ped_pending);
      else pass_cnt++;
      rst = 1'b1;
      repeat (3) @(negedge clk100MHz);
      total_cnt++;
      if (state !== 3'd5) $display("FAIL reset_hold_allred: got %0d want 5", state);
      else pass_cnt++;
      do_tick(1'b0);
      total_cnt++;
      if ({state, ns_light, ew_light, walk} !== expect_vec(0))
         $display("FAIL reset_first_tick: got st=%0d ns=%b ew=%b want st=0 ns=001 ew=100", state, ns_light, ew_light);
      else pass_cnt++;
   endtask

   task automatic test_cycle;
      int exp_st[16] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 4, 4, 5, 0};
      for (int i = 0; i < 16; i++) begin
         do_tick(1'b0);
         total_cnt++;
         if ({state, ns_light, ew_light, walk} !== expect_vec(exp_st[i]))
            $display("FAIL cycle_tick%0d: got st=%0d ns=%b ew=%b walk=%b want st=%0d",
                     i + 1, state, ns_light, ew_light, walk, exp_st[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_latency;
      ticks(4);
      @(negedge clk100MHz);
      slow_clk = 1'b1;
      @(posedge clk100MHz); #1;
      total_cnt++;
      if (state !== 3'd0) $display("FAIL latency_edge_k: got %0d want 0", state);
      else pass_cnt++;
      @(posedge clk100MHz); #1;
      total_cnt++;
      if (state !== 3'd0) $display("FAIL latency_edge_k1: got %0d want 0", state);
      else pass_cnt++;
      @(posedge clk100MHz); #1;
      total_cnt++;
      if ({state, ns_light} !== {3'd1, 3'b010}) $display("FAIL latency_edge_k2: got st=%0d ns=%b want st=1 ns=010", state, ns_light);
      else pass_cnt++;
      repeat (8) @(negedge clk100MHz);
      slow_clk = 1'b0;
      repeat (10) @(negedge clk100MHz);
      do_tick(1'b0);
      total_cnt++;
      if (state !== 3'd1) $display("FAIL single_tick_width: got %0d want 1", state);
      else pass_cnt++;
      ticks(2);
      total_cnt++;
      if ({state, ns_light, ew_light, walk} !== expect_vec(3)) $display("FAIL to_ew_green: got st=%0d want 3", state);
      else pass_cnt++;
   endtask

   task automatic test_ped_service;
      @(negedge clk100MHz);
      ped_req = 1'b1;
      repeat (3) @(posedge clk100MHz);
      #1;
      total_cnt++;
      if (ped_pending !== 1'b1) $display("FAIL ped_latch: got %b want 1", ped_pending);
      else pass_cnt++;
      ped_req = 1'b0;
      ticks(5);
      total_cnt++;
      if ({state, ped_pending} !== {3'd4, 1'b1}) $display("FAIL ped_green_full: got st=%0d pend=%b want st=4 pend=1", state, ped_pending);
      else pass_cnt++;
      ticks(2);
      total_cnt++;
      if (state !== 3'd5) $display("FAIL ped_allred2: got %0d want 5", state);
      else pass_cnt++;
      do_tick(1'b0);
      total_cnt++;
      if ({state, ns_light, ew_light, walk, ped_pending} !== {expect_vec(6), 1'b0})
         $display("FAIL ped_walk_entry: got st=%0d walk=%b pend=%b want st=6 walk=1 pend=0", state, walk, ped_pending);
      else pass_cnt++;
      ticks(3);
      total_cnt++;
      if ({state, walk} !== {3'd6, 1'b1}) $display("FAIL ped_walk_len: got st=%0d walk=%b want 6/1", state, walk);
      else pass_cnt++;
      do_tick(1'b0);
      total_cnt++;
      if ({state, ns_light, ew_light, walk} !== expect_vec(0)) $display("FAIL ped_walk_exit: got st=%0d walk=%b want st=0 walk=0", state, walk);
      else pass_cnt++;
   endtask

   task automatic test_request_edges;
      int walk_ticks = 0;
      @(negedge clk100MHz);
      ped_req = 1'b1;
      for (int i = 0; i < 36; i++) begin
         do_tick(1'b0);
         if (state == 3'd6) walk_ticks++;
      end
      ped_req = 1'b0;
      total_cnt++;
      if ({walk_ticks, state, ped_pending} !== {32'd4, 3'd0, 1'b0})
         $display("FAIL held_single_walk: got walk_ticks=%0d st=%0d pend=%b want 4/0/0", walk_ticks, state, ped_pending);
      else pass_cnt++;
      do_tick(1'b1);
      ticks(7);
      total_cnt++;
      if (state !== 3'd6) $display("FAIL press_walk_after_ar1: got %0d want 6", state);
      else pass_cnt++;
      do_tick(1'b1);
      total_cnt++;
      if ({state, ped_pending} !== {3'd6, 1'b0}) $display("FAIL press_in_walk_ignored: got st=%0d pend=%b want 6/0", state, ped_pending);
      else pass_cnt++;
      ticks(3);
      total_cnt++;
      if (state !== 3'd3) $display("FAIL walk_to_ew_green: got %0d want 3", state);
      else pass_cnt++;
      ticks(8);
      total_cnt++;
      if (state !== 3'd0) $display("FAIL no_second_walk: got %0d want 0", state);
      else pass_cnt++;
      ticks(7);
      do_tick(1'b1);
      total_cnt++;
      if ({state, ped_pending} !== {3'd3, 1'b1}) $display("FAIL press_on_exit_tick: got st=%0d pend=%b want 3/1", state, ped_pending);
      else pass_cnt++;
      ticks(8);
      total_cnt++;
      if ({state, walk} !== {3'd6, 1'b1}) $display("FAIL exit_press_served: got st=%0d walk=%b want 6/1", state, walk);
      else pass_cnt++;
      ticks(4);
      total_cnt++;
      if (state !== 3'd0) $display("FAIL walk_to_ns_green: got %0d want 0", state);
      else pass_cnt++;
   endtask

   task automatic test_enable_freeze;
      ticks(2);
      enable = 1'b0;
      ticks(2);
      do_tick(1'b1);
      ticks(3);
      total_cnt++;
      if ({state, ped_pending} !== {3'd0, 1'b1}) $display("FAIL freeze_hold: got st=%0d pend=%b want 0/1", state, ped_pending);
      else pass_cnt++;
      enable = 1'b1;
      ticks(2);
      total_cnt++;
      if (state !== 3'd0) $display("FAIL freeze_resume_green: got %0d want 0", state);
      else pass_cnt++;
      do_tick(1'b0);
      total_cnt++;
      if ({state, ns_light} !== {3'd1, 3'b010}) $display("FAIL freeze_resume_yellow: got st=%0d ns=%b want 1/010", state, ns_light);
      else pass_cnt++;
      ticks(3);
      total_cnt++;
      if ({state, walk} !== {3'd6, 1'b1}) $display("FAIL freeze_press_walk: got st=%0d walk=%b want 6/1", state, walk);
      else pass_cnt++;
   endtask

   task automatic test_async_reset;
      @(negedge clk100MHz);
      #2 rst = 1'b0;
      #1;
      total_cnt++;
      if ({state, ns_light, ew_light, walk, ped_pending} !== {3'd5, 3'b100, 3'b100, 1'b0, 1'b0})
         $display("FAIL async_reset: got st=%0d ns=%b ew=%b walk=%b pend=%b want 5/100/100/0/0",
                  state, ns_light, ew_light, walk, ped_pending);
      else pass_cnt++;
      repeat (3) @(negedge clk100MHz);
      rst = 1'b1;
      do_tick(1'b0);
      total_cnt++;
      if ({state, ns_light, ew_light, walk} !== expect_vec(0)) $display("FAIL restart_ns_green: got st=%0d want 0", state);
      else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_cycle;
      test_latency;
      test_ped_service;
      test_request_edges;
      test_enable_freeze;
      test_async_reset;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
